// File: rtl/ctrl_pipe.sv
// Control pipeline for the pipelined MIPS core: ID/EX, EX/MEM and MEM/WB control
// registers with load-use stall, branch/jump flush and EX forwarding selection.
module ctrl_pipe #(
  parameter int REG_W    = 5,
  parameter int LINK_REG = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             validD,
  input  logic [1:0]       MemRegD,
  input  logic             MemWrD,
  input  logic             BrnchD,
  input  logic             BrnchneD,
  input  logic             ALUsrcD,
  input  logic [1:0]       RegDsD,
  input  logic             RegWrD,
  input  logic             jmpD,
  input  logic [2:0]       ALUopD,
  input  logic [REG_W-1:0] rsD,
  input  logic [REG_W-1:0] rtD,
  input  logic [REG_W-1:0] rdD,
  input  logic             ZeroE,
  output logic             ALUsrcE,
  output logic [2:0]       ALUopE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             PCSrcE,
  output logic             JumpD,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             MemWrM,
  output logic             RegWrM,
  output logic [REG_W-1:0] WriteRegM,
  output logic [1:0]       MemRegW,
  output logic             RegWrW,
  output logic [REG_W-1:0] WriteRegW
);

  localparam logic [REG_W-1:0] ZERO_IDX = {REG_W{1'b0}};
  localparam logic [REG_W-1:0] LINK_IDX = REG_W'(LINK_REG);

  // MEM result outranks WB because it is the younger write to the same register.
  function automatic logic [1:0] fwd_sel(
    input logic             src,
    input logic [REG_W-1:0] src_idx,
    input logic             wr_m,
    input logic [REG_W-1:0] dst_m,
    input logic             wr_w,
    input logic [REG_W-1:0] dst_w
  );
    logic [1:0] sel;
    if (src && wr_m && (dst_m != ZERO_IDX) && (dst_m == src_idx)) begin
      sel = 2'b10;
    end else if (src && wr_w && (dst_w != ZERO_IDX) && (dst_w == src_idx)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // E stage
  logic             regwr_e_q, regwr_e_d;
  logic             memwr_e_q, memwr_e_d;
  logic             brnch_e_q, brnch_e_d;
  logic             brnchne_e_q, brnchne_e_d;
  logic             alusrc_e_q, alusrc_e_d;
  logic [1:0]       memreg_e_q, memreg_e_d;
  logic [2:0]       aluop_e_q, aluop_e_d;
  logic [REG_W-1:0] rs_e_q, rs_e_d;
  logic [REG_W-1:0] rt_e_q, rt_e_d;
  logic [REG_W-1:0] wreg_e_q, wreg_e_d;

  // M stage
  logic             regwr_m_q, regwr_m_d;
  logic             memwr_m_q, memwr_m_d;
  logic [1:0]       memreg_m_q, memreg_m_d;
  logic [REG_W-1:0] wreg_m_q, wreg_m_d;

  // W stage
  logic             regwr_w_q, regwr_w_d;
  logic [1:0]       memreg_w_q, memreg_w_d;
  logic [REG_W-1:0] wreg_w_q, wreg_w_d;

  logic [REG_W-1:0] wreg_id_s;
  logic             pcsrc_s;
  logic             load_in_e_s;
  logic             src_match_s;
  logic             lwstall_s;
  logic             jump_s;
  logic             bubble_e_s;

  // Destination register select for the instruction in ID.
  always_comb begin
    wreg_id_s = ZERO_IDX;
    case (RegDsD)
      2'd0:    wreg_id_s = rtD;
      2'd1:    wreg_id_s = rdD;
      2'd2:    wreg_id_s = LINK_IDX;
      default: wreg_id_s = ZERO_IDX;
    endcase
  end

  // Branch resolution, load-use detection and jump acceptance.
  always_comb begin
    pcsrc_s     = (brnch_e_q & ZeroE) | (brnchne_e_q & ~ZeroE);
    load_in_e_s = regwr_e_q & (memreg_e_q == 2'd1) & (wreg_e_q != ZERO_IDX);
    src_match_s = (wreg_e_q == rsD) | (wreg_e_q == rtD);
    // A taken branch makes the ID instruction wrong-path, so it must not stall.
    lwstall_s   = load_in_e_s & src_match_s & validD & ~pcsrc_s;
    jump_s      = jmpD & validD & ~lwstall_s;
    bubble_e_s  = lwstall_s | pcsrc_s;
  end

  // Next-state for E (bubble on stall or taken branch); M and W always advance.
  always_comb begin
    regwr_e_d   = 1'b0;
    memwr_e_d   = 1'b0;
    brnch_e_d   = 1'b0;
    brnchne_e_d = 1'b0;
    alusrc_e_d  = 1'b0;
    memreg_e_d  = 2'd0;
    aluop_e_d   = 3'd0;
    rs_e_d      = ZERO_IDX;
    rt_e_d      = ZERO_IDX;
    wreg_e_d    = ZERO_IDX;
    if (bubble_e_s) begin
      regwr_e_d = 1'b0;
    end else begin
      regwr_e_d   = RegWrD & validD;
      memwr_e_d   = MemWrD & validD;
      brnch_e_d   = BrnchD & validD & ~jmpD;
      brnchne_e_d = BrnchneD & validD & ~jmpD;
      alusrc_e_d  = ALUsrcD;
      memreg_e_d  = MemRegD;
      aluop_e_d   = ALUopD;
      rs_e_d      = rsD;
      rt_e_d      = rtD;
      wreg_e_d    = wreg_id_s;
    end

    regwr_m_d  = regwr_e_q;
    memwr_m_d  = memwr_e_q;
    memreg_m_d = memreg_e_q;
    wreg_m_d   = wreg_e_q;

    regwr_w_d  = regwr_m_q;
    memreg_w_d = memreg_m_q;
    wreg_w_d   = wreg_m_q;
  end

  // Pipeline control registers; reset discards every in-flight control word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regwr_e_q   <= 1'b0;
      memwr_e_q   <= 1'b0;
      brnch_e_q   <= 1'b0;
      brnchne_e_q <= 1'b0;
      alusrc_e_q  <= 1'b0;
      memreg_e_q  <= 2'd0;
      aluop_e_q   <= 3'd0;
      rs_e_q      <= ZERO_IDX;
      rt_e_q      <= ZERO_IDX;
      wreg_e_q    <= ZERO_IDX;
      regwr_m_q   <= 1'b0;
      memwr_m_q   <= 1'b0;
      memreg_m_q  <= 2'd0;
      wreg_m_q    <= ZERO_IDX;
      regwr_w_q   <= 1'b0;
      memreg_w_q  <= 2'd0;
      wreg_w_q    <= ZERO_IDX;
    end else begin
      regwr_e_q   <= regwr_e_d;
      memwr_e_q   <= memwr_e_d;
      brnch_e_q   <= brnch_e_d;
      brnchne_e_q <= brnchne_e_d;
      alusrc_e_q  <= alusrc_e_d;
      memreg_e_q  <= memreg_e_d;
      aluop_e_q   <= aluop_e_d;
      rs_e_q      <= rs_e_d;
      rt_e_q      <= rt_e_d;
      wreg_e_q    <= wreg_e_d;
      regwr_m_q   <= regwr_m_d;
      memwr_m_q   <= memwr_m_d;
      memreg_m_q  <= memreg_m_d;
      wreg_m_q    <= wreg_m_d;
      regwr_w_q   <= regwr_w_d;
      memreg_w_q  <= memreg_w_d;
      wreg_w_q    <= wreg_w_d;
    end
  end

  assign ALUsrcE   = alusrc_e_q;
  assign ALUopE    = aluop_e_q;
  assign ForwardAE = fwd_sel(1'b1, rs_e_q, regwr_m_q, wreg_m_q, regwr_w_q, wreg_w_q);
  assign ForwardBE = fwd_sel(1'b1, rt_e_q, regwr_m_q, wreg_m_q, regwr_w_q, wreg_w_q);
  assign PCSrcE    = pcsrc_s;
  assign JumpD     = jump_s;
  assign StallF    = lwstall_s;
  assign StallD    = lwstall_s;
  assign FlushD    = pcsrc_s | jump_s;
  assign MemWrM    = memwr_m_q;
  assign RegWrM    = regwr_m_q;
  assign WriteRegM = wreg_m_q;
  assign MemRegW   = memreg_w_q;
  assign RegWrW    = regwr_w_q;
  assign WriteRegW = wreg_w_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: an instruction-record pipeline model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_ctrl_pipe;

  logic       clk = 1'b0;
  logic       reset;
  logic       validD, MemWrD, BrnchD, BrnchneD, ALUsrcD, RegWrD, jmpD, ZeroE;
  logic [1:0] MemRegD, RegDsD;
  logic [2:0] ALUopD;
  logic [4:0] rsD, rtD, rdD;
  logic       ALUsrcE, PCSrcE, JumpD, StallF, StallD, FlushD, MemWrM, RegWrM, RegWrW;
  logic [2:0] ALUopE;
  logic [1:0] ForwardAE, ForwardBE, MemRegW;
  logic [4:0] WriteRegM, WriteRegW;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ctrl_pipe #(.REG_W(5), .LINK_REG(31)) dut (
    .clk(clk), .reset(reset), .validD(validD), .MemRegD(MemRegD), .MemWrD(MemWrD),
    .BrnchD(BrnchD), .BrnchneD(BrnchneD), .ALUsrcD(ALUsrcD), .RegDsD(RegDsD),
    .RegWrD(RegWrD), .jmpD(jmpD), .ALUopD(ALUopD), .rsD(rsD), .rtD(rtD), .rdD(rdD),
    .ZeroE(ZeroE), .ALUsrcE(ALUsrcE), .ALUopE(ALUopE), .ForwardAE(ForwardAE),
    .ForwardBE(ForwardBE), .PCSrcE(PCSrcE), .JumpD(JumpD), .StallF(StallF),
    .StallD(StallD), .FlushD(FlushD), .MemWrM(MemWrM), .RegWrM(RegWrM),
    .WriteRegM(WriteRegM), .MemRegW(MemRegW), .RegWrW(RegWrW), .WriteRegW(WriteRegW)
  );

  // One in-flight instruction as the pipeline sees it.
  typedef struct packed {
    logic       regwr, memwr, br, brne;
    logic [1:0] memreg;
    logic       alusrc;
    logic [2:0] aluop;
    logic [4:0] rs, rt, wr;
  } instr_t;

  instr_t ex_m, mem_m, wb_m;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic instr_t decode_id();
    instr_t c;
    c = '0;
    c.regwr  = RegWrD & validD;
    c.memwr  = MemWrD & validD;
    c.br     = BrnchD & validD & ~jmpD;
    c.brne   = BrnchneD & validD & ~jmpD;
    c.memreg = MemRegD;
    c.alusrc = ALUsrcD;
    c.aluop  = ALUopD;
    c.rs     = rsD;
    c.rt     = rtD;
    case (RegDsD)
      2'd0:    c.wr = rtD;
      2'd1:    c.wr = rdD;
      2'd2:    c.wr = 5'd31;
      default: c.wr = 5'd0;
    endcase
    return c;
  endfunction

  function automatic logic m_taken();
    return (ex_m.br && ZeroE) || (ex_m.brne && !ZeroE);
  endfunction

  function automatic logic m_lwstall();
    logic is_load, uses;
    is_load = ex_m.regwr && (ex_m.memreg == 2'd1) && (ex_m.wr != 5'd0);
    uses    = (ex_m.wr == rsD) || (ex_m.wr == rtD);
    return is_load && uses && validD && !m_taken();
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] src);
    if (mem_m.regwr && mem_m.wr != 5'd0 && mem_m.wr == src) return 2'b10;
    if (wb_m.regwr && wb_m.wr != 5'd0 && wb_m.wr == src) return 2'b01;
    return 2'b00;
  endfunction

  // Model advance: the youngest record moves down one stage per edge.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_m  <= '0;
      mem_m <= '0;
      wb_m  <= '0;
    end else begin
      wb_m  <= mem_m;
      mem_m <= ex_m;
      ex_m  <= (m_lwstall() || m_taken()) ? instr_t'('0) : decode_id();
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic jmp_ok;
    jmp_ok = jmpD && validD && !m_lwstall();
    check("ALUsrcE",   8'(ALUsrcE),   8'(ex_m.alusrc));
    check("ALUopE",    8'(ALUopE),    8'(ex_m.aluop));
    check("ForwardAE", 8'(ForwardAE), 8'(m_fwd(ex_m.rs)));
    check("ForwardBE", 8'(ForwardBE), 8'(m_fwd(ex_m.rt)));
    check("PCSrcE",    8'(PCSrcE),    8'(m_taken()));
    check("JumpD",     8'(JumpD),     8'(jmp_ok));
    check("StallF",    8'(StallF),    8'(m_lwstall()));
    check("StallD",    8'(StallD),    8'(m_lwstall()));
    check("FlushD",    8'(FlushD),    8'(m_taken() || jmp_ok));
    check("MemWrM",    8'(MemWrM),    8'(mem_m.memwr));
    check("RegWrM",    8'(RegWrM),    8'(mem_m.regwr));
    check("WriteRegM", 8'(WriteRegM), 8'(mem_m.wr));
    check("MemRegW",   8'(MemRegW),   8'(wb_m.memreg));
    check("RegWrW",    8'(RegWrW),    8'(wb_m.regwr));
    check("WriteRegW", 8'(WriteRegW), 8'(wb_m.wr));
  end

  task automatic put(input logic v, input logic [1:0] mr, input logic mw, input logic br,
                     input logic bne, input logic as, input logic [1:0] rds, input logic rw,
                     input logic j, input logic [2:0] op, input logic [4:0] rs,
                     input logic [4:0] rt, input logic [4:0] rd);
    validD = v; MemRegD = mr; MemWrD = mw; BrnchD = br; BrnchneD = bne; ALUsrcD = as;
    RegDsD = rds; RegWrD = rw; jmpD = j; ALUopD = op; rsD = rs; rtD = rt; rdD = rd;
  endtask

  task automatic bub();
    put(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1;
    ZeroE = 1'b0;
    bub();
    #2;
    check("rst_fwdA",   8'(ForwardAE), 8'd0);
    check("rst_stallD", 8'(StallD),    8'd0);
    check("rst_regwrW", 8'(RegWrW),    8'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // lw $8 followed by a dependent add
    put(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 3'd0, 5'd0, 5'd8, 5'd0);
    tick();
    put(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 3'd2, 5'd8, 5'd9, 5'd10);
    #1;
    check("lu_stallF", 8'(StallF), 8'd1);
    check("lu_stallD", 8'(StallD), 8'd1);
    tick(); #1;
    check("lu_one_cycle", 8'(StallD),    8'd0);
    check("lu_bubble_op", 8'(ALUopE),    8'd0);
    check("lu_lw_in_m",   8'(WriteRegM), 8'd8);
    tick();
    bub(); #1;
    check("lu_fwdA_wb", 8'(ForwardAE), 8'd1);
    check("lu_add_op",  8'(ALUopE),    8'd2);
    tick();

    // addi $5 ; addi $5 ; add $6,$5,$5 -> MEM wins over WB
    put(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 3'd1, 5'd0, 5'd5, 5'd0);
    tick();
    tick();
    put(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 3'd2, 5'd5, 5'd5, 5'd6);
    tick();
    put(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 3'd1, 5'd0, 5'd0, 5'd0);
    #1;
    check("fw_A_mem", 8'(ForwardAE), 8'd2);
    check("fw_B_mem", 8'(ForwardBE), 8'd2);
    tick();
    put(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 3'd2, 5'd0, 5'd0, 5'd7);
    tick();
    bub(); #1;
    check("fw_zero_A", 8'(ForwardAE), 8'd0);
    check("fw_zero_B", 8'(ForwardBE), 8'd0);
    tick();

    // beq taken, wrong-path addi must never reach M
    put(1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 3'd6, 5'd1, 5'd2, 5'd0);
    tick();
    ZeroE = 1'b1;
    put(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 3'd1, 5'd0, 5'd7, 5'd0);
    #1;
    check("beq_pcsrc", 8'(PCSrcE), 8'd1);
    check("beq_flush", 8'(FlushD), 8'd1);
    tick();
    bub(); #1;
    check("beq_e_zero",  8'(ALUopE), 8'd0);
    check("beq_pcsrc_0", 8'(PCSrcE), 8'd0);
    tick(); #1;
    check("beq_m_bubble", 8'(RegWrM), 8'd0);

    // bne: not taken with ZeroE=1, taken with ZeroE=0
    put(1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 3'd6, 5'd1, 5'd2, 5'd0);
    tick();
    bub(); #1;
    check("bne_nt_pcsrc", 8'(PCSrcE), 8'd0);
    check("bne_nt_flush", 8'(FlushD), 8'd0);
    ZeroE = 1'b0; #1;
    check("bne_t_pcsrc", 8'(PCSrcE), 8'd1);
    tick();

    // jal: link register and PC+4 select arrive at W after three edges
    put(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 3'd0, 5'd0, 5'd0, 5'd0);
    #1;
    check("jal_jump",  8'(JumpD),  8'd1);
    check("jal_flush", 8'(FlushD), 8'd1);
    tick();
    bub();
    tick();
    tick(); #1;
    check("jal_regwrW", 8'(RegWrW),    8'd1);
    check("jal_wregW",  8'(WriteRegW), 8'd31);
    check("jal_memregW", 8'(MemRegW),  8'd2);
    tick();

    // taken branch in EX overrides a load-use stall
    put(1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 3'd0, 5'd0, 5'd8, 5'd0);
    tick();
    ZeroE = 1'b1;
    put(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 3'd2, 5'd8, 5'd9, 5'd10);
    #1;
    check("sim_br_stall", 8'(StallD), 8'd0);
    check("sim_br_flush", 8'(FlushD), 8'd1);
    tick();
    ZeroE = 1'b0;
    bub();
    tick();

    // jump held by a load-use stall, accepted the next cycle
    put(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 3'd0, 5'd0, 5'd9, 5'd0);
    tick();
    put(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 3'd0, 5'd9, 5'd0, 5'd0);
    #1;
    check("sim_j_stall", 8'(StallD), 8'd1);
    check("sim_j_held",  8'(JumpD),  8'd0);
    tick(); #1;
    check("sim_j_go",    8'(JumpD),  8'd1);
    check("sim_j_nostl", 8'(StallD), 8'd0);
    tick();
    bub();
    tick();

    // reset with a register write in flight
    put(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 3'd1, 5'd0, 5'd3, 5'd0);
    tick();
    bub();
    tick(); #1;
    check("rt_pre_regwrM", 8'(RegWrM), 8'd1);
    reset = 1'b1; #1;
    check("rt_regwrM", 8'(RegWrM),    8'd0);
    check("rt_wregM",  8'(WriteRegM), 8'd0);
    check("rt_aluop",  8'(ALUopE),    8'd0);
    tick();
    put(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 3'd5, 5'd0, 5'd4, 5'd0);
    reset = 1'b0; #1;
    check("rt_rel_e",  8'(ALUopE), 8'd0);
    tick(); #1;
    check("rt_first_e", 8'(ALUopE), 8'd5);
    check("rt_no_old_w", 8'(RegWrW), 8'd0);
    bub();
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
